// File: rtl/flatten_unit_pkg.sv
// Shared constants, element/map/vector types and helpers for the flatten stage.
// Stream support is selected by the FLATTEN_STREAM_EN macro in the consuming files.
package flatten_unit_pkg;

  localparam int unsigned DataWidth      = 8;
  localparam int unsigned PoolOfmapSize  = 2;
  localparam int unsigned PoolPixelCount = PoolOfmapSize * PoolOfmapSize;

  typedef logic [DataWidth-1:0] elem_t;
  typedef elem_t [0:PoolOfmapSize-1][0:PoolOfmapSize-1] map_t;
  typedef elem_t [0:PoolPixelCount-1] vec_t;

  typedef enum logic {StIdle, StStream} ser_state_e;

  // Row-major position of map element [r][c].
  function automatic int unsigned flat_index(int unsigned r, int unsigned c, int unsigned side);
    return r * side + c;
  endfunction

endpackage

// File: rtl/flatten_unit_if.sv
// Handshake/data bundle for flatten_unit; the stream_* signals exist only when
// FLATTEN_STREAM_EN is defined.
interface flatten_unit_if #(
  parameter int unsigned DATA_WIDTH       = flatten_unit_pkg::DataWidth,
  parameter int unsigned POOL_OFMAP_SIZE  = flatten_unit_pkg::PoolOfmapSize,
  parameter int unsigned POOL_PIXEL_COUNT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE
);

  logic                                                           in_valid;
  logic                                                           in_ready;
  logic [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1][DATA_WIDTH-1:0] feature;
  logic [0:POOL_PIXEL_COUNT-1][DATA_WIDTH-1:0]                     flatten_out;
  logic                                                           out_valid;

`ifdef FLATTEN_STREAM_EN
  logic [DATA_WIDTH-1:0] stream_data;
  logic                  stream_valid;
  logic                  stream_ready;
  logic                  stream_last;

  modport master (
    output in_valid, feature, stream_ready,
    input  in_ready, flatten_out, out_valid, stream_data, stream_valid, stream_last
  );

  modport slave (
    input  in_valid, feature, stream_ready,
    output in_ready, flatten_out, out_valid, stream_data, stream_valid, stream_last
  );
`else
  modport master (
    output in_valid, feature,
    input  in_ready, flatten_out, out_valid
  );

  modport slave (
    input  in_valid, feature,
    output in_ready, flatten_out, out_valid
  );
`endif

endinterface

// File: rtl/flatten_unit_serializer.sv
// flatten_serializer: streams the captured vector one element per handshake and
// holds off new captures while busy. Instantiated only under FLATTEN_STREAM_EN.
module flatten_serializer
  import flatten_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DataWidth,
  parameter int unsigned PIXEL_COUNT = PoolPixelCount
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [0:PIXEL_COUNT-1][DATA_WIDTH-1:0] vec,
  input  logic                                   stream_ready,
  output logic [DATA_WIDTH-1:0]                  stream_data,
  output logic                                   stream_valid,
  output logic                                   stream_last,
  output logic                                   in_ready
);

  localparam int unsigned    IdxW    = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PIXEL_COUNT - 1);

  ser_state_e      state_q;
  logic [IdxW-1:0] idx_q;
  logic            ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StStream;
            idx_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        StStream: begin
          if (stream_ready) begin
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
              idx_q   <= '0;
              ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs depend only on registers: vec cannot change while a stream is active.
  always_comb begin
    stream_valid = (state_q == StStream);
    stream_last  = stream_valid && (idx_q == LastIdx);
    stream_data  = stream_valid ? vec[idx_q] : '0;
    in_ready     = ready_q;
  end

endmodule

// File: rtl/flatten_unit.sv
// Registered row-major flatten of the pooled map. With FLATTEN_STREAM_EN the
// captured vector is also serialized and captures are blocked while streaming.
module flatten_unit
  import flatten_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DataWidth,
  parameter int unsigned POOL_OFMAP_SIZE  = PoolOfmapSize,
  parameter int unsigned POOL_PIXEL_COUNT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE
) (
  input logic           clk,
  input logic           reset,
  flatten_unit_if.slave bus
);

  typedef logic [0:POOL_PIXEL_COUNT-1][DATA_WIDTH-1:0] flat_t;

  flat_t flat_d;
  flat_t flat_q;
  logic  out_valid_q;
  logic  capture;

  assign capture = bus.in_valid && bus.in_ready;

  always_comb begin
    flat_d = '0;
    for (int unsigned r = 0; r < POOL_OFMAP_SIZE; r++) begin
      for (int unsigned c = 0; c < POOL_OFMAP_SIZE; c++) begin
        flat_d[flat_index(r, c, POOL_OFMAP_SIZE)] = bus.feature[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flat_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= capture;
      if (capture) begin
        flat_q <= flat_d;
      end
    end
  end

  assign bus.flatten_out = flat_q;
  assign bus.out_valid   = out_valid_q;

`ifdef FLATTEN_STREAM_EN
  flatten_serializer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PIXEL_COUNT (POOL_PIXEL_COUNT)
  ) u_serializer (
    .clk          (clk),
    .reset        (reset),
    .start        (capture),
    .vec          (flat_q),
    .stream_ready (bus.stream_ready),
    .stream_data  (bus.stream_data),
    .stream_valid (bus.stream_valid),
    .stream_last  (bus.stream_last),
    .in_ready     (bus.in_ready)
  );
`else
  assign bus.in_ready = 1'b1;
`endif

endmodule

// File: tb/tb_flatten_unit.sv
// Scoreboard bench for flatten_unit; stream scenarios are built when
// FLATTEN_STREAM_EN is defined.
module tb_flatten_unit;

  localparam int unsigned S  = 2;
  localparam int unsigned P  = S * S;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flatten_unit_if #(.DATA_WIDTH(DW), .POOL_OFMAP_SIZE(S)) bus ();

  flatten_unit #(.DATA_WIDTH(DW), .POOL_OFMAP_SIZE(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          beats    = 0;
  int          b0;
  logic [31:0] exp_q[$];
  logic [8:0]  str_q[$];
  logic [5:0]  pat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element k of v (k = 0 is the most significant byte) goes to map[k/S][k%S].
  task automatic set_map(input logic [31:0] v);
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < S; c++) begin
        bus.feature[r][c] = v[31 - 8 * (r * S + c) -: 8];
      end
    end
  endtask

  task automatic load(input logic [31:0] v);
    int i = 0;
    while (!bus.in_ready && i < 50) begin
      tick();
      i++;
    end
    if (!bus.in_ready) check_eq("rdy_timeout", bus.in_ready, 1);
    set_map(v);
    bus.in_valid = 1'b1;
    exp_q.push_back(v);
`ifdef FLATTEN_STREAM_EN
    for (int k = 0; k < P; k++) begin
      str_q.push_back({(k == P - 1) ? 1'b1 : 1'b0, v[31 - 8 * k -: 8]});
    end
`endif
    tick();
    bus.in_valid = 1'b0;
  endtask

`ifdef FLATTEN_STREAM_EN
  task automatic drain();
    int i = 0;
    bus.stream_ready = 1'b1;
    while (str_q.size() != 0 && i < 50) begin
      tick();
      i++;
    end
    check_eq("drain", str_q.size(), 0);
    check_eq("drain_rdy", bus.in_ready, 1);
  endtask
`endif

  // Output monitor: pops expectations whenever the DUT reports new data or a beat.
  initial begin
    logic       stall_seen;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;
    stall_seen = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_seen = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) check_eq("ov_spurious", bus.out_valid, 0);
          else check_eq("flat_out", bus.flatten_out, exp_q.pop_front());
        end
`ifdef FLATTEN_STREAM_EN
        if (stall_seen && bus.stream_valid) begin
          check_eq("stall_data", bus.stream_data, prev_data);
          check_eq("stall_last", bus.stream_last, prev_last);
        end
        stall_seen = bus.stream_valid && !bus.stream_ready;
        prev_data  = bus.stream_data;
        prev_last  = bus.stream_last;
        if (bus.stream_valid && bus.stream_ready) begin
          beats++;
          if (str_q.size() == 0) begin
            check_eq("beat_spurious", bus.stream_valid, 0);
          end else begin
            e = str_q.pop_front();
            check_eq("beat_data", bus.stream_data, e[7:0]);
            check_eq("beat_last", bus.stream_last, e[8]);
          end
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.feature  = '0;
`ifdef FLATTEN_STREAM_EN
    bus.stream_ready = 1'b1;
`endif
    tick();
    tick();
    check_eq("rst_flat", bus.flatten_out, 0);
    check_eq("rst_ov", bus.out_valid, 0);
    reset = 1'b0;
    tick();
    check_eq("rst_rdy", bus.in_ready, 1);

    load(32'h01020304);
    check_eq("ov_pulse", bus.out_valid, 1);
    check_eq("flat_seq", bus.flatten_out, 32'h01020304);
    tick();
    check_eq("ov_drop", bus.out_valid, 0);

    load(32'h24810963);
    for (int k = 0; k < 5; k++) begin
      check_eq("hold_flat", bus.flatten_out, 32'h24810963);
      check_eq("hold_ov", bus.out_valid, (k == 0) ? 1 : 0);
      tick();
    end

    reset = 1'b1;
    exp_q.delete();
    str_q.delete();
    tick();
    check_eq("rst2_flat", bus.flatten_out, 0);
    check_eq("rst2_ov", bus.out_valid, 0);
`ifdef FLATTEN_STREAM_EN
    check_eq("rst2_sv", bus.stream_valid, 0);
`endif
    reset = 1'b0;
    tick();
    check_eq("rst2_rdy", bus.in_ready, 1);

`ifndef FLATTEN_STREAM_EN
    // Back-to-back captures keep out_valid high.
    set_map(32'hA1B2C3D4);
    bus.in_valid = 1'b1;
    exp_q.push_back(32'hA1B2C3D4);
    tick();
    check_eq("b2b_1", bus.out_valid, 1);
    set_map(32'h5E6F7A8B);
    exp_q.push_back(32'h5E6F7A8B);
    tick();
    check_eq("b2b_2", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    tick();
    check_eq("b2b_end", bus.out_valid, 0);
    check_eq("b2b_flat", bus.flatten_out, 32'h5E6F7A8B);
`else
    // Backpressure pattern 1,0,1,1,0,1 (bit 0 first).
    bus.stream_ready = 1'b0;
    b0  = beats;
    pat = 6'b101101;
    load(32'h01020304);
    for (int k = 0; k < 6; k++) begin
      bus.stream_ready = pat[k];
      check_eq("bp_busy", bus.in_ready, 0);
      tick();
    end
    check_eq("bp_rdy", bus.in_ready, 1);
    check_eq("bp_sv", bus.stream_valid, 0);
    check_eq("bp_beats", beats - b0, 4);

    // Capture attempt while busy must be dropped.
    bus.stream_ready = 1'b0;
    load(32'h01020304);
    tick();
    set_map(32'h09090909);
    bus.in_valid = 1'b1;
    check_eq("busy_rdy", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0;
    check_eq("busy_flat", bus.flatten_out, 32'h01020304);
    drain();
    check_eq("busy_flat2", bus.flatten_out, 32'h01020304);

    // Reset after the second beat aborts the stream.
    bus.stream_ready = 1'b1;
    load(32'h01020304);
    tick();
    tick();
    reset = 1'b1;
    str_q.delete();
    exp_q.delete();
    tick();
    reset = 1'b0;
    check_eq("rstmid_sv", bus.stream_valid, 0);
    check_eq("rstmid_rdy", bus.in_ready, 1);
    tick();
    check_eq("rstmid_sv2", bus.stream_valid, 0);
    b0 = beats;
    load(32'h05060708);
    drain();
    check_eq("rstmid_beats", beats - b0, 4);
`endif

    tick();
    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("str_q_empty", str_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
